// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TX FIFO feeding a uart_tx start/done sequencer,
// RX FIFO fed by uart_rx, and a status register with sticky error flags.
module uart_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [7:0]  addr,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_active,
  input  logic        tx_done,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic [1:0]  tx_state_dbg
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);

  localparam logic [7:0] ADDR_TXD  = 8'h18;
  localparam logic [7:0] ADDR_RXD  = 8'h1C;
  localparam logic [7:0] ADDR_STAT = 8'h20;

  localparam logic [TXW:0] TX_INC = {{TXW{1'b0}}, 1'b1};
  localparam logic [RXW:0] RX_INC = {{RXW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  tx_state_t state;

  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TXW:0] tx_wr_ptr;
  logic [TXW:0] tx_rd_ptr;
  logic         tx_full;
  logic         tx_empty;

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RXW:0] rx_wr_ptr;
  logic [RXW:0] rx_rd_ptr;
  logic         rx_full;
  logic         rx_empty;

  logic        tx_ovf;
  logic        rx_ovr;
  logic        tx_busy;
  logic        txd_wr;
  logic        rxd_rd;
  logic        stat_rd;
  logic        tx_push;
  logic        tx_pop;
  logic        rx_push;
  logic        rx_pop;
  logic [31:0] stat_word;
  logic [31:0] rd_word;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign tx_full  = (tx_wr_ptr[TXW] != tx_rd_ptr[TXW]) &&
                    (tx_wr_ptr[TXW-1:0] == tx_rd_ptr[TXW-1:0]);
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RXW] != rx_rd_ptr[RXW]) &&
                    (rx_wr_ptr[RXW-1:0] == rx_rd_ptr[RXW-1:0]);
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);

  assign txd_wr  = sel && wen && (addr == ADDR_TXD);
  assign rxd_rd  = sel && ren && (addr == ADDR_RXD);
  assign stat_rd = sel && ren && (addr == ADDR_STAT);

  // Full/empty are evaluated before this cycle's pop, so a push into a full
  // FIFO is rejected even when the other side drains an entry on the same edge.
  assign tx_push = txd_wr && !tx_full;
  assign tx_pop  = (state == IDLE) && !tx_empty;
  assign rx_push = rx_dv && !rx_full;
  assign rx_pop  = rxd_rd && !rx_empty;

  assign tx_busy      = (state != IDLE) || tx_active;
  assign stat_word    = {26'b0, tx_ovf, tx_busy, rx_ovr, !rx_empty, tx_empty, tx_full};
  assign tx_state_dbg = state;

  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_RXD:  if (!rx_empty) rd_word = {24'b0, rx_mem[rx_rd_ptr[RXW-1:0]]};
      ADDR_STAT: rd_word = stat_word;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TXW-1:0]] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr[RXW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_INC;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_INC;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_INC;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_INC;
    end
  end

  // Sticky flags: a new error in the same cycle as a STAT read stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      if (txd_wr && tx_full) tx_ovf <= 1'b1;
      else if (stat_rd)      tx_ovf <= 1'b0;
      if (rx_dv && rx_full)  rx_ovr <= 1'b1;
      else if (stat_rd)      rx_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else if (sel && ren) rdata <= rd_word;
  end

  // uart_tx handshake: tx_dv is a one-cycle start strobe; tx_byte is held
  // until the tx_done pulse, and the next start comes no earlier than two
  // cycles after that pulse (SEND -> GAP -> IDLE).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
    end else begin
      tx_dv <= 1'b0;
      case (state)
        IDLE: if (!tx_empty) begin
          tx_dv   <= 1'b1;
          tx_byte <= tx_mem[tx_rd_ptr[TXW-1:0]];
          state   <= SEND;
        end
        SEND: if (tx_done) state <= GAP;
        GAP:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
